// File: rtl/alu_op_executor.sv
// ALU operation executor: valid/ready op intake, registered result and PSR flags.
// Define ALU_OP_EXECUTOR_MUL_EN to include the 16-cycle shift-add multiplier.
module alu_op_executor (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [7:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] result,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [4:0]  flags,
    output logic        illegal_op
);
    localparam int FC = 4;
    localparam int FL = 3;
    localparam int FF = 2;
    localparam int FZ = 1;
    localparam int FN = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd1
`ifdef ALU_OP_EXECUTOR_MUL_EN
        , MUL = 2'd2
`endif
    } state_t;

    typedef enum logic [3:0] {
        K_ADD, K_ADDU, K_ADDC, K_SUB, K_CMP, K_AND, K_OR,
        K_XOR, K_MOV, K_LSH, K_MUL, K_ILL
    } kind_t;

    state_t      state_reg, state_next;
    kind_t       kind;
    logic [15:0] result_reg, alu_result;
    logic [4:0]  flags_reg, alu_flags;
    logic        illegal_reg, alu_illegal;
    logic [16:0] sum;
    logic [15:0] diff;
    logic [3:0]  rshift;
    logic        op_accept;

`ifdef ALU_OP_EXECUTOR_MUL_EN
    logic [15:0] mul_acc_reg, mul_mcand_reg, mul_mplier_reg;
    logic [4:0]  mul_cnt_reg;
`endif

    // Register forms select by ext; immediate forms ignore ext.
    always_comb begin
        kind = K_ILL;
        case (op[7:4])
            4'b0000: begin
                case (op[3:0])
                    4'b0101: kind = K_ADD;
                    4'b0110: kind = K_ADDU;
                    4'b0111: kind = K_ADDC;
                    4'b1001: kind = K_SUB;
                    4'b1011: kind = K_CMP;
                    4'b0001: kind = K_AND;
                    4'b0010: kind = K_OR;
                    4'b0011: kind = K_XOR;
                    4'b1101: kind = K_MOV;
`ifdef ALU_OP_EXECUTOR_MUL_EN
                    4'b1110: kind = K_MUL;
`endif
                    default: kind = K_ILL;
                endcase
            end
            4'b0101: kind = K_ADD;
            4'b0110: kind = K_ADDU;
            4'b1001: kind = K_SUB;
            4'b1011: kind = K_CMP;
            4'b0001: kind = K_AND;
            4'b0010: kind = K_OR;
            4'b0011: kind = K_XOR;
            4'b1101: kind = K_MOV;
            4'b1000: if (op[3:0] == 4'b0100) kind = K_LSH;
            default: kind = K_ILL;
        endcase
    end

    always_comb begin
        sum         = {1'b0, b} + {1'b0, a} + {16'd0, (kind == K_ADDC) && flags_reg[FC]};
        diff        = b - a;
        rshift      = 4'd0 - a[3:0];
        alu_result  = '0;
        alu_flags   = flags_reg;
        alu_illegal = 1'b0;
        case (kind)
            K_ADD, K_ADDC: begin
                alu_result    = sum[15:0];
                alu_flags[FC] = sum[16];
                alu_flags[FF] = (a[15] == b[15]) && (sum[15] != b[15]);
            end
            K_ADDU: alu_result = sum[15:0];
            K_SUB: begin
                alu_result    = diff;
                alu_flags[FC] = a > b;
                alu_flags[FF] = (a[15] != b[15]) && (diff[15] != b[15]);
            end
            K_CMP: begin
                alu_result    = b;
                alu_flags[FZ] = a == b;
                alu_flags[FL] = b < a;
                alu_flags[FN] = $signed(b) < $signed(a);
            end
            K_AND: alu_result = a & b;
            K_OR:  alu_result = a | b;
            K_XOR: alu_result = a ^ b;
            K_MOV: alu_result = a;
            // Negative shift count means right shift by its magnitude.
            K_LSH: alu_result = a[15] ? (b >> rshift) : (b << a[3:0]);
`ifdef ALU_OP_EXECUTOR_MUL_EN
            K_MUL: alu_result = '0;
`endif
            default: alu_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        op_ready   = 1'b0;
        case (state_reg)
            IDLE: begin
                op_ready = !reset;
                if (op_valid) begin
`ifdef ALU_OP_EXECUTOR_MUL_EN
                    state_next = (kind == K_MUL) ? MUL : DONE;
`else
                    state_next = DONE;
`endif
                end
            end
            DONE: if (result_ready) state_next = IDLE;
`ifdef ALU_OP_EXECUTOR_MUL_EN
            MUL: if (mul_cnt_reg == 5'd16) state_next = DONE;
`endif
            default: state_next = IDLE;
        endcase
    end

    assign op_accept = op_valid && op_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            result_reg  <= '0;
            flags_reg   <= '0;
            illegal_reg <= 1'b0;
`ifdef ALU_OP_EXECUTOR_MUL_EN
            mul_acc_reg    <= '0;
            mul_mcand_reg  <= '0;
            mul_mplier_reg <= '0;
            mul_cnt_reg    <= '0;
`endif
        end else begin
            state_reg <= state_next;
            if (op_accept) begin
`ifdef ALU_OP_EXECUTOR_MUL_EN
                if (kind == K_MUL) begin
                    mul_acc_reg    <= '0;
                    mul_mcand_reg  <= a;
                    mul_mplier_reg <= b;
                    mul_cnt_reg    <= '0;
                end else begin
                    result_reg  <= alu_result;
                    flags_reg   <= alu_flags;
                    illegal_reg <= alu_illegal;
                end
`else
                result_reg  <= alu_result;
                flags_reg   <= alu_flags;
                illegal_reg <= alu_illegal;
`endif
            end
`ifdef ALU_OP_EXECUTOR_MUL_EN
            // Sixteen iterations, then one more edge to publish the product.
            if (state_reg == MUL) begin
                if (mul_cnt_reg != 5'd16) begin
                    mul_acc_reg    <= mul_acc_reg + (mul_mplier_reg[0] ? mul_mcand_reg : 16'd0);
                    mul_mcand_reg  <= mul_mcand_reg << 1;
                    mul_mplier_reg <= mul_mplier_reg >> 1;
                    mul_cnt_reg    <= mul_cnt_reg + 5'd1;
                end else begin
                    result_reg  <= mul_acc_reg;
                    illegal_reg <= 1'b0;
                end
            end
`endif
        end
    end

    assign result       = result_reg;
    assign flags        = flags_reg;
    assign illegal_op   = illegal_reg;
    assign result_valid = (state_reg == DONE);

endmodule

// File: tb/tb_alu_op_executor.sv
// Randomized self-checking bench for alu_op_executor against an arithmetic reference model.
module tb_alu_op_executor;
    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  op;
    logic [15:0] a, b;
    logic [15:0] result;
    logic        result_valid;
    logic        result_ready;
    logic [4:0]  flags;
    logic        illegal_op;

    int checks = 0;
    int errors = 0;
    logic [4:0] model_flags = '0;

    alu_op_executor dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op(op), .a(a), .b(b), .result(result), .result_valid(result_valid),
        .result_ready(result_ready), .flags(flags), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Flags packed {C, L, F, Z, N}; all arithmetic done on plain integers.
    task automatic ref_model(input logic [7:0] o, input logic [15:0] x, input logic [15:0] y,
                             input logic [4:0] fin, output logic [15:0] r, output logic [4:0] fo,
                             output logic ill, output int lat);
        int ua, ub, sa, sb, s, sh;
        string name;
        ua = int'(x); ub = int'(y);
        sa = int'($signed(x)); sb = int'($signed(y));
        r = '0; fo = fin; ill = 1'b0; lat = 1; name = "ILL";
        case (o[7:4])
            4'h0: case (o[3:0])
                4'h5: name = "ADD";  4'h6: name = "ADDU"; 4'h7: name = "ADDC";
                4'h9: name = "SUB";  4'hB: name = "CMP";  4'h1: name = "AND";
                4'h2: name = "OR";   4'h3: name = "XOR";  4'hD: name = "MOV";
`ifdef ALU_OP_EXECUTOR_MUL_EN
                4'hE: name = "MUL";
`endif
                default: name = "ILL";
            endcase
            4'h5: name = "ADD";  4'h6: name = "ADDU"; 4'h9: name = "SUB";
            4'hB: name = "CMP";  4'h1: name = "AND";  4'h2: name = "OR";
            4'h3: name = "XOR";  4'hD: name = "MOV";
            4'h8: name = (o[3:0] == 4'h4) ? "LSH" : "ILL";
            default: name = "ILL";
        endcase
        case (name)
            "ADD", "ADDC": begin
                s = ub + ua + ((name == "ADDC") ? int'(fin[4]) : 0);
                r = 16'(s);
                fo[4] = s > 65535;
                s = sb + sa + ((name == "ADDC") ? int'(fin[4]) : 0);
                fo[2] = (s > 32767) || (s < -32768);
            end
            "ADDU": r = 16'(ub + ua);
            "SUB": begin
                r = 16'(ub - ua);
                fo[4] = ua > ub;
                s = sb - sa;
                fo[2] = (s > 32767) || (s < -32768);
            end
            "CMP": begin
                r = y;
                fo[1] = ua == ub;
                fo[3] = ub < ua;
                fo[0] = sb < sa;
            end
            "AND": r = x & y;
            "OR":  r = x | y;
            "XOR": r = x ^ y;
            "MOV": r = x;
            "LSH": begin
                if (ua < 32768) begin
                    sh = ua % 16;
                    r = 16'((ub << sh) % 65536);
                end else begin
                    sh = (65536 - ua) % 16;
                    r = 16'(ub >> sh);
                end
            end
            "MUL": begin
                r = 16'((ua * ub) % 65536);
                lat = 17;
            end
            default: ill = 1'b1;
        endcase
    endtask

    task automatic do_op(input logic [7:0] o, input logic [15:0] x, input logic [15:0] y,
                         input int hold, input int pulse_at);
        logic [15:0] er;
        logic [4:0]  ef;
        logic        ei;
        int          el, lat;
        ref_model(o, x, y, model_flags, er, ef, ei, el);
        check("accept_ready", 32'(op_ready), 32'd1);
        op = o; a = x; b = y; op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0; op = 8'($urandom); a = 16'($urandom); b = 16'($urandom);
        lat = 1;
        while (!result_valid && lat < 40) begin
            if (lat == pulse_at) begin
                op_valid = 1'b1;
                check("busy_ready", 32'(op_ready), 32'd0);
            end
            @(posedge clk); #1;
            op_valid = 1'b0;
            lat++;
        end
        check("latency", 32'(lat), 32'(el));
        check("result", 32'(result), 32'(er));
        check("flags", 32'(flags), 32'(ef));
        check("illegal", 32'(illegal_op), 32'(ei));
        model_flags = ef;
        for (int i = 0; i < hold; i++) begin
            result_ready = 1'b0;
            @(posedge clk); #1;
            check("hold_valid", 32'(result_valid), 32'd1);
            check("hold_result", 32'(result), 32'(er));
            check("hold_flags", 32'(flags), 32'(ef));
            check("hold_ready", 32'(op_ready), 32'd0);
        end
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        check("idle_ready", 32'(op_ready), 32'd1);
        check("idle_valid", 32'(result_valid), 32'd0);
        $display("TXN op=%02h a=%04h b=%04h result=%04h flags=%05b illegal=%0b lat=%0d",
                 o, x, y, er, ef, ei, lat);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_result"}, 32'(result), 32'd0);
        check({tag, "_valid"}, 32'(result_valid), 32'd0);
        check({tag, "_flags"}, 32'(flags), 32'd0);
        check({tag, "_illegal"}, 32'(illegal_op), 32'd0);
        check({tag, "_ready"}, 32'(op_ready), 32'd0);
    endtask

    initial begin
        int seen;
        logic [7:0] o;
        reset = 1'b1; op_valid = 1'b0; op = '0; a = '0; b = '0; result_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset = 1'b0;
        #1;
        check("rst_release_ready", 32'(op_ready), 32'd1);

        do_op(8'h05, 16'h7FFF, 16'h0001, 0, 0);
        check("add_ovf_F", 32'(flags[2]), 32'd1);
        do_op(8'h6A, 16'hFFFF, 16'h0001, 0, 0);
        do_op(8'h0B, 16'h0001, 16'hFFFF, 0, 0);
        do_op(8'h09, 16'($urandom), 16'($urandom), 10, 0);
        do_op(8'h84, 16'hFFFD, 16'h8000, 0, 0);
        do_op(8'h84, 16'h0003, 16'h1234, 0, 0);
        do_op(8'h07, 16'h0001, 16'hFFFF, 0, 0);
        do_op(8'h0E, 16'h0003, 16'h0005, 0, 5);
        repeat (3) begin
            @(posedge clk); #1;
            check("no_second_op", 32'(result_valid), 32'd0);
        end
        do_op(8'hF0, 16'h1234, 16'h5678, 1, 0);
        do_op(8'h05, 16'hFFFF, 16'hFFFF, 0, 0);

        // Reset in the middle of an operation must discard it.
        op = 8'h0E; a = 16'h1234; b = 16'h00FF; op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("midrst_release_ready", 32'(op_ready), 32'd1);
        model_flags = '0;
        result_ready = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (result_valid) seen++;
        end
        result_ready = 1'b0;
        check("midrst_no_valid", 32'(seen), 32'd0);

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 3))
                0: o = 8'($urandom);
                1: o = {4'h0, 4'($urandom)};
                2: o = 8'h84;
                default: o = {4'($urandom), 4'($urandom)};
            endcase
            do_op(o, 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_op_executor.md
ALU_OP_EXECUTOR -- requirements
Module: alu_op_executor

Interface
REQ-001 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port op_valid, input, 1: op/a/b valid this cycle.
REQ-004 SHALL have port op_ready, output, 1: executor accepts op this cycle.
REQ-005 SHALL have port op, input, 8: ALU control code {opcode[3:0], ext[3:0]} as produced by the decode-side ALU control.
REQ-006 SHALL have ports a and b, input, 16 each: a = source operand, b = destination operand (or sign-extended immediate).
REQ-007 SHALL have port result, output, 16: registered result.
REQ-008 SHALL have port result_valid, output, 1: result/flags/illegal_op valid.
REQ-009 SHALL have port result_ready, input, 1: consumer takes result.
REQ-010 SHALL have port flags, output, 5: PSR {C, L, F, Z, N} = bits [4:0].
REQ-011 SHALL have port illegal_op, output, 1: unsupported code for current result.

Function
REQ-012 SHALL implement states IDLE, MUL, DONE; op_ready = 1 only in IDLE and not in reset.
REQ-013 SHALL accept an op when op_valid and op_ready are both 1; op/a/b captured on that edge.
REQ-014 SHALL ignore op_valid in MUL and DONE (no capture, no side effect).
REQ-015 Single-cycle ops: IDLE -> DONE on accept; result_valid = 1 the cycle after accept.
REQ-016 DONE SHALL hold result, flags, illegal_op stable until result_ready = 1, then -> IDLE; throughput one op per two cycles minimum.
REQ-017 Decode (register forms, op[7:4]=0000): ext 0101 ADD, 0110 ADDU, 0111 ADDC, 1001 SUB, 1011 CMP, 0001 AND, 0010 OR, 0011 XOR, 1101 MOV, 1110 MUL.
REQ-018 Decode (immediate forms, ext ignored): op[7:4] 0101 ADDI, 0110 ADDUI, 1001 SUBI, 1011 CMPI, 0001 ANDI, 0010 ORI, 0011 XORI, 1101 MOVI; op = 1000_0100 LSH.
REQ-019 ADD/ADDI: result = b+a mod 2^16; C = carry out; F = signed overflow; L, Z, N unchanged.
REQ-020 ADDU/ADDUI: result = b+a mod 2^16; all flags unchanged.
REQ-021 ADDC: result = b+a+C(stored); C, F updated as ADD.
REQ-022 SUB/SUBI: result = b-a mod 2^16; C = borrow (a>b unsigned); F = signed overflow.
REQ-023 CMP/CMPI: result = b unchanged; Z = (a==b); L = (b<a unsigned); N = (b<a signed); C, F unchanged.
REQ-024 AND/OR/XOR/MOV (and immediates): bitwise/copy a; flags unchanged.
REQ-025 LSH: a[15] = 0 -> b << a[3:0]; a[15] = 1 -> b >> (-a)[3:0], zero fill; flags unchanged.
REQ-026 MUL: IDLE -> MUL on accept; 16 shift-add iterations, one per cycle; low 16 bits of a*b unsigned; -> DONE; result_valid 17 cycles after accept; flags unchanged.
REQ-027 Unsupported code: result = 0, flags unchanged, illegal_op = 1, single-cycle latency; illegal_op = 0 for every supported op.
REQ-028 flags SHALL update only on the DONE-entry edge of the owning op, never on hold cycles.

Reset
REQ-029 Reset asserted: state IDLE, result 0, result_valid 0, flags 00000, illegal_op 0, op_ready 0, MUL counter 0.
REQ-030 Reset mid-MUL or in DONE SHALL discard the op; no result_valid after deassert.
REQ-031 op_ready SHALL go 1 on the first clk edge-free cycle after reset deasserts.

Configuration
REQ-032 Macro ALU_OP_EXECUTOR_MUL_EN defined: MUL per REQ-026, MUL state present.
REQ-033 Macro undefined: MUL state and datapath absent; op 0000_1110 handled per REQ-027 (illegal_op = 1, result 0, latency 1).

Verification
REQ-034 ADD a=0x7FFF b=0x0001 -> result 0x8000, F=1, C=0, result_valid next cycle.
REQ-035 ADDUI op=0110_xxxx a=0xFFFF b=0x0001 -> result 0x0000, flags unchanged from prior value.
REQ-036 CMP a=0x0001 b=0xFFFF -> result 0xFFFF, Z=0, L=0, N=1.
REQ-037 MUL (MUL_EN) a=0x0003 b=0x0005, op_valid pulsed again at cycle 5 -> result 0x000F at cycle 17, second op not accepted.
REQ-038 result_ready held 0 for 10 cycles in DONE -> result/flags stable, op_ready 0; release -> IDLE, op_ready 1.
REQ-039 Reset asserted at MUL cycle 8 -> all outputs per REQ-029 immediately; no result_valid after release.
